// File: rtl/game_pkg.sv
// Shared definitions between the input conditioner and the game manager.
//
// Contents:
//   DIR_*  : 2-bit direction codes used by the game manager movement logic
//   BTN_*  : bit positions of each switch inside the 4-bit button vectors
//   encode_dir : priority encoder up > down > left > right, 0 when idle
package game_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

    // An idle vector also returns DIR_UP (code 0).
    // The game manager qualifies the code with dir_valid.
    function automatic logic [1:0] encode_dir(input logic [3:0] lvl);
        logic [1:0] code;
        code = DIR_UP;
        if (lvl[BTN_UP])         code = DIR_UP;
        else if (lvl[BTN_DOWN])  code = DIR_DOWN;
        else if (lvl[BTN_LEFT])  code = DIR_LEFT;
        else if (lvl[BTN_RIGHT]) code = DIR_RIGHT;
        return code;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, debounce counter, stable level
// and a registered rising-edge pulse.
//
// Ports:
//   clk, clk_reset : system clock, synchronous active-high reset
//   raw            : asynchronous switch input
//   level          : debounced level
//   rise           : 1-cycle pulse, coincident with the first cycle level==1
//
// Parameter DB_CYCLES is the number of consecutive samples at the
// synchronizer output that must differ from the stable level before the
// level flips. DB_CYCLES must be at least 2.
module debounce_channel #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic clk_reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        if (s2_q == stable_q) begin
            // Any agreeing sample restarts the window.
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // This is the DB_CYCLES-th consecutive differing sample.
            // The rise pulse is set on the same edge as the level,
            // so both are high together in the first cycle.
            stable_d = s2_q;
            cnt_d    = '0;
            rise_d   = s2_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the four raw board switches for the game manager.
//
// Ports:
//   clk, clk_reset : system clock, synchronous active-high reset
//   switch_up/down/left/right : raw asynchronous switches
//   game_tick      : 1-cycle pulse from the game manager; it consumes btn_held
//   btn_level[3:0] : debounced levels {up,down,left,right}
//   btn_rise[3:0]  : 1-cycle pulse on each 0->1 of btn_level
//   btn_held[3:0]  : sticky press flags, cleared only by game_tick
//   dir_code[1:0]  : priority-encoded direction, up > down > left > right
//   dir_valid      : any btn_level bit set
//
// Handshake: there is no back-pressure. game_tick is a single-cycle strobe.
// The game manager reads btn_held in the same cycle game_tick is high.
// The flags clear on the following edge. A press whose btn_rise lands in
// the tick cycle survives the clear, so no press is lost.
module input_conditioner
    import game_pkg::*;
#(
    parameter int CLK_HZ              = 100_000_000,
    parameter int DEBOUNCE_MS         = 10,
    parameter bit IS_SIM              = 1'b0,
    parameter int SIM_DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clk_reset,
    input  logic       switch_up,
    input  logic       switch_down,
    input  logic       switch_left,
    input  logic       switch_right,
    input  logic       game_tick,
    output logic [3:0] btn_level,
    output logic [3:0] btn_rise,
    output logic [3:0] btn_held,
    output logic [1:0] dir_code,
    output logic       dir_valid
);

    localparam int DB_CYCLES = IS_SIM ? SIM_DEBOUNCE_CYCLES
                                      : (CLK_HZ / 1000) * DEBOUNCE_MS;

    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] rise;

    always_comb begin
        raw            = '0;
        raw[BTN_UP]    = switch_up;
        raw[BTN_DOWN]  = switch_down;
        raw[BTN_LEFT]  = switch_left;
        raw[BTN_RIGHT] = switch_right;
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES)
        ) u_chan (
            .clk       (clk),
            .clk_reset (clk_reset),
            .raw       (raw[i]),
            .level     (level[i]),
            .rise      (rise[i])
        );
    end

    logic [3:0] held_q, held_d;
    logic [1:0] dir_code_q, dir_code_d;
    logic       dir_valid_q, dir_valid_d;

    always_comb begin
        held_d = held_q;
        for (int i = 0; i < 4; i++) begin
            if (rise[i])        held_d[i] = 1'b1;
            else if (game_tick) held_d[i] = 1'b0;
        end
        dir_code_d  = encode_dir(level);
        dir_valid_d = |level;
    end

    always_ff @(posedge clk) begin
        if (clk_reset) begin
            held_q      <= '0;
            dir_code_q  <= DIR_UP;
            dir_valid_q <= 1'b0;
        end else begin
            held_q      <= held_d;
            dir_code_q  <= dir_code_d;
            dir_valid_q <= dir_valid_d;
        end
    end

    assign btn_level = level;
    assign btn_rise  = rise;
    assign btn_held  = held_q;
    assign dir_code  = dir_code_q;
    assign dir_valid = dir_valid_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with IS_SIM=1, 4-cycle debounce.
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled at the same point, after the edge has settled.
// "k" counts rising edges since the last input change.
module tb_input_conditioner;

    logic       clk;
    logic       clk_reset;
    logic       switch_up, switch_down, switch_left, switch_right;
    logic       game_tick;
    logic [3:0] btn_level, btn_rise, btn_held;
    logic [1:0] dir_code;
    logic       dir_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    input_conditioner #(
        .CLK_HZ              (100_000_000),
        .DEBOUNCE_MS         (10),
        .IS_SIM              (1'b1),
        .SIM_DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .clk_reset    (clk_reset),
        .switch_up    (switch_up),
        .switch_down  (switch_down),
        .switch_left  (switch_left),
        .switch_right (switch_right),
        .game_tick    (game_tick),
        .btn_level    (btn_level),
        .btn_rise     (btn_rise),
        .btn_held     (btn_held),
        .dir_code     (dir_code),
        .dir_valid    (dir_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] exp_lvl, exp_rise, exp_held;
        clk_reset = 1'b1;
        switch_up = 1'b1; switch_down = 1'b0; switch_left = 1'b0; switch_right = 1'b0;
        game_tick = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            total_cnt++;
            if ({btn_level, btn_rise, btn_held, dir_code, dir_valid} !== 15'd0)
                $display("FAIL reset_outputs k=%0d lvl=%b rise=%b held=%b code=%0d valid=%b expected all 0",
                         k, btn_level, btn_rise, btn_held, dir_code, dir_valid);
            else pass_cnt++;
        end
        clk_reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_lvl  = (k >= 6) ? 4'b1000 : 4'b0000;
            exp_rise = (k == 6) ? 4'b1000 : 4'b0000;
            exp_held = (k >= 7) ? 4'b1000 : 4'b0000;
            total_cnt++;
            if (btn_level !== exp_lvl || btn_rise !== exp_rise || btn_held !== exp_held)
                $display("FAIL reset_release k=%0d lvl=%b rise=%b held=%b expected %b %b %b",
                         k, btn_level, btn_rise, btn_held, exp_lvl, exp_rise, exp_held);
            else pass_cnt++;
            total_cnt++;
            if (dir_valid !== (k >= 7) || dir_code !== 2'd0)
                $display("FAIL reset_dir k=%0d code=%0d valid=%b expected 0 %b",
                         k, dir_code, dir_valid, (k >= 7));
            else pass_cnt++;
        end
    endtask

    // Entered with switch_up debounced high and btn_held[3] set.
    task automatic test_release();
        switch_up = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            total_cnt++;
            if (btn_level[3] !== (k < 6) || btn_rise !== 4'b0000 || btn_held !== 4'b1000)
                $display("FAIL release k=%0d lvl=%b rise=%b held=%b expected lvl3=%b rise=0000 held=1000",
                         k, btn_level, btn_rise, btn_held, (k < 6));
            else pass_cnt++;
        end
        total_cnt++;
        if (dir_valid !== 1'b0)
            $display("FAIL release_dir valid=%b expected 0", dir_valid);
        else pass_cnt++;
        pulse_tick();
        total_cnt++;
        if (btn_held !== 4'b0000)
            $display("FAIL release_tick_clear held=%b expected 0000", btn_held);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        switch_left = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) switch_left = 1'b0;
            step();
            total_cnt++;
            if (btn_level !== 4'b0000 || btn_rise !== 4'b0000 || btn_held !== 4'b0000)
                $display("FAIL glitch k=%0d lvl=%b rise=%b held=%b expected all 0000",
                         k, btn_level, btn_rise, btn_held);
            else pass_cnt++;
        end
    endtask

    task automatic test_press();
        switch_right = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            total_cnt++;
            if (btn_level !== ((k >= 6) ? 4'b0001 : 4'b0000) ||
                btn_rise  !== ((k == 6) ? 4'b0001 : 4'b0000) ||
                btn_held  !== ((k >= 7) ? 4'b0001 : 4'b0000))
                $display("FAIL press k=%0d lvl=%b rise=%b held=%b", k, btn_level, btn_rise, btn_held);
            else pass_cnt++;
            total_cnt++;
            if (dir_valid !== (k >= 7) || dir_code !== ((k >= 7) ? 2'd3 : 2'd0))
                $display("FAIL press_dir k=%0d code=%0d valid=%b expected %0d %b",
                         k, dir_code, dir_valid, (k >= 7) ? 3 : 0, (k >= 7));
            else pass_cnt++;
        end
        switch_right = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        total_cnt++;
        if (btn_level !== 4'b0000 || btn_held !== 4'b0001)
            $display("FAIL press_after_release lvl=%b held=%b expected 0000 0001", btn_level, btn_held);
        else pass_cnt++;
        pulse_tick();
        total_cnt++;
        if (btn_held !== 4'b0000)
            $display("FAIL press_tick_clear held=%b expected 0000", btn_held);
        else pass_cnt++;
    endtask

    task automatic test_tick_collision();
        switch_down = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        total_cnt++;
        if (btn_rise !== 4'b0100)
            $display("FAIL collision_rise rise=%b expected 0100", btn_rise);
        else pass_cnt++;
        pulse_tick();   // tick lands in the btn_rise[2] cycle
        total_cnt++;
        if (btn_held !== 4'b0100 || btn_rise !== 4'b0000)
            $display("FAIL collision_held held=%b rise=%b expected 0100 0000", btn_held, btn_rise);
        else pass_cnt++;
        step();
        total_cnt++;
        if (btn_held !== 4'b0100)
            $display("FAIL collision_hold held=%b expected 0100", btn_held);
        else pass_cnt++;
        pulse_tick();
        total_cnt++;
        if (btn_held !== 4'b0000)
            $display("FAIL collision_clear held=%b expected 0000", btn_held);
        else pass_cnt++;
        switch_down = 1'b0;
        for (int k = 1; k <= 8; k++) step();
    endtask

    task automatic test_priority();
        switch_down = 1'b1;
        switch_left = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) begin
                total_cnt++;
                if (btn_level !== 4'b0110 || btn_rise !== 4'b0110)
                    $display("FAIL prio_simul lvl=%b rise=%b expected 0110 0110", btn_level, btn_rise);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (dir_code !== 2'd1 || dir_valid !== 1'b1)
            $display("FAIL prio_down code=%0d valid=%b expected 1 1", dir_code, dir_valid);
        else pass_cnt++;
        switch_down = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) begin
                total_cnt++;
                if (dir_code !== 2'd1 || btn_level !== 4'b0010)
                    $display("FAIL prio_lag code=%0d lvl=%b expected 1 0010", dir_code, btn_level);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (dir_code !== 2'd2 || dir_valid !== 1'b1)
            $display("FAIL prio_left code=%0d valid=%b expected 2 1", dir_code, dir_valid);
        else pass_cnt++;
        switch_left = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        total_cnt++;
        if (dir_code !== 2'd0 || dir_valid !== 1'b0)
            $display("FAIL prio_idle code=%0d valid=%b expected 0 0", dir_code, dir_valid);
        else pass_cnt++;
        pulse_tick();
        total_cnt++;
        if (btn_held !== 4'b0000)
            $display("FAIL prio_clear held=%b expected 0000", btn_held);
        else pass_cnt++;
    endtask

    // A reset in the middle of a debounce window discards the partial count.
    task automatic test_reset_mid();
        switch_up = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        clk_reset = 1'b1;
        step();
        clk_reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            total_cnt++;
            if (btn_level !== ((k >= 6) ? 4'b1000 : 4'b0000))
                $display("FAIL reset_mid k=%0d lvl=%b expected %b",
                         k, btn_level, (k >= 6) ? 4'b1000 : 4'b0000);
            else pass_cnt++;
        end
        switch_up = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        pulse_tick();
    endtask

    initial begin
        test_reset();
        test_release();
        test_glitch();
        test_press();
        test_tick_collision();
        test_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
